// File: rtl/johnson_phase_sequencer.sv
// Johnson (twisted-ring) phase sequencer: runs N full loops or free-runs,
// with hold/abort, one-hot phase decode and self-correction of illegal ring states.
module johnson_phase_sequencer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     loops,
    input  logic                 stop,
    input  logic                 hold,
    output logic [WIDTH-1:0]     q,
    output logic [2*WIDTH-1:0]   phase,
    output logic                 busy,
    output logic                 done,
    output logic                 wrap,
    output logic                 illegal
);

    localparam int unsigned PH_W = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_q;
    logic [CNT_W-1:0]   r_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;
    logic               r_illegal;

    state_t             w_state;
    logic [WIDTH-1:0]   w_q;
    logic [CNT_W-1:0]   w_rem;
    logic               w_done;
    logic               w_wrap;
    logic               w_illegal;
    logic [PH_W-1:0]    w_phase;
    logic               w_legal;

    // One-hot decode: low-ones patterns map to bits 0..WIDTH, high-ones to WIDTH+1..
    always_comb begin
        w_phase = '0;
        for (int i = 0; i <= int'(WIDTH); i++) begin
            w_phase[i] = (r_q == ~(ALL_ONES << i));
        end
        for (int j = 1; j < int'(WIDTH); j++) begin
            w_phase[int'(WIDTH) + j] = (r_q == (ALL_ONES << j));
        end
        w_legal = |w_phase;
    end

    // Next-state and next-output logic; priority stop > correction > hold > advance
    always_comb begin
        w_state   = r_state;
        w_q       = r_q;
        w_rem     = r_rem;
        w_done    = 1'b0;
        w_wrap    = 1'b0;
        w_illegal = r_illegal;

        if (stop) begin
            w_state = S_IDLE;
            w_q     = '0;
            w_rem   = '0;
        end else if (!w_legal) begin
            w_q       = '0;
            w_illegal = 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_q = '0;
                    if (start) begin
                        w_state   = S_RUN;
                        w_rem     = loops;
                        w_illegal = 1'b0;
                    end
                end
                S_RUN: begin
                    if (hold) begin
                        w_state = S_HOLD;
                    end else begin
                        w_q = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
                        if (r_q == MSB_ONLY) begin
                            w_wrap = 1'b1;
                            if (r_rem != '0) begin
                                w_rem = r_rem - CNT_W'(1);
                                if (r_rem == CNT_W'(1)) begin
                                    w_state = S_IDLE;
                                    w_done  = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!hold) begin
                        w_state = S_RUN;
                    end
                end
                default: begin
                    w_state = S_IDLE;
                    w_q     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_rem     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_q       <= w_q;
            r_rem     <= w_rem;
            r_busy    <= (w_state != S_IDLE);
            r_done    <= w_done;
            r_wrap    <= w_wrap;
            r_illegal <= w_illegal;
        end
    end

    assign q       = r_q;
    assign phase   = w_phase;
    assign busy    = r_busy;
    assign done    = r_done;
    assign wrap    = r_wrap;
    assign illegal = r_illegal;

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Scoreboard bench for johnson_phase_sequencer (WIDTH=4, CNT_W=8): a cycle model
// pushes expected outputs per edge, a monitor pops and compares after each edge.
module tb_johnson_phase_sequencer;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] loops;
    logic          stop;
    logic          hold;
    logic [W-1:0]  q;
    logic [2*W-1:0] phase;
    logic          busy;
    logic          done;
    logic          wrap;
    logic          illegal;

    johnson_phase_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .loops(loops), .stop(stop),
        .hold(hold), .q(q), .phase(phase), .busy(busy), .done(done),
        .wrap(wrap), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   q;
        logic [2*W-1:0] phase;
        logic           busy;
        logic           done;
        logic           wrap;
        logic           ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (0=IDLE, 1=RUN, 2=HOLD)
    logic [W-1:0]  m_q;
    int            m_state;
    logic [CW-1:0] m_rem;
    logic          m_ill;

    function automatic logic [W-1:0] seq_val(input int k);
        if (k <= 4) return W'((1 << k) - 1);
        return W'(4'hF << (k - 4));
    endfunction

    function automatic int idx_of(input logic [W-1:0] v);
        for (int k = 0; k < 8; k++) if (v == seq_val(k)) return k;
        return -1;
    endfunction

    function automatic logic [2*W-1:0] exp_phase(input logic [W-1:0] v);
        int k;
        k = idx_of(v);
        if (k < 0) return '0;
        return (2*W)'(1 << k);
    endfunction

    task automatic model_reset();
        m_q = '0; m_state = 0; m_rem = '0; m_ill = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic hd, input logic [CW-1:0] lp);
        exp_t e;
        int   k;
        e.done = 1'b0;
        e.wrap = 1'b0;
        k = idx_of(m_q);
        if (sp) begin
            m_state = 0; m_rem = '0; m_q = '0;
        end else if (k < 0) begin
            m_q = '0; m_ill = 1'b1;
        end else if (m_state == 0) begin
            m_q = '0;
            if (st) begin m_state = 1; m_rem = lp; m_ill = 1'b0; end
        end else if (m_state == 1) begin
            if (hd) m_state = 2;
            else begin
                if (k == 7) begin
                    e.wrap = 1'b1;
                    if (m_rem != 0) begin
                        m_rem = m_rem - 8'd1;
                        if (m_rem == 0) begin m_state = 0; e.done = 1'b1; end
                    end
                end
                m_q = seq_val((k + 1) % 8);
            end
        end else begin
            if (!hd) m_state = 1;
        end
        e.q     = m_q;
        e.phase = exp_phase(m_q);
        e.busy  = (m_state != 0);
        e.ill   = m_ill;
        sb.push_back(e);
    endtask

    // Drive one edge's inputs at a negedge, log the expectation, return at next negedge
    task automatic step(input logic st, input logic sp, input logic hd, input logic [CW-1:0] lp);
        start = st; stop = sp; hold = hd; loops = lp;
        model_step(st, sp, hd, lp);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks += 6;
            if (q !== e.q)           begin errors++; $display("FAIL sb_q got=%b exp=%b t=%0t", q, e.q, $time); end
            if (phase !== e.phase)   begin errors++; $display("FAIL sb_phase got=%b exp=%b t=%0t", phase, e.phase, $time); end
            if (busy !== e.busy)     begin errors++; $display("FAIL sb_busy got=%b exp=%b t=%0t", busy, e.busy, $time); end
            if (done !== e.done)     begin errors++; $display("FAIL sb_done got=%b exp=%b t=%0t", done, e.done, $time); end
            if (wrap !== e.wrap)     begin errors++; $display("FAIL sb_wrap got=%b exp=%b t=%0t", wrap, e.wrap, $time); end
            if (illegal !== e.ill)   begin errors++; $display("FAIL sb_illegal got=%b exp=%b t=%0t", illegal, e.ill, $time); end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0; loops = '0;
        model_reset();
        #3;
        checks += 3;
        if (q !== 4'b0000)        begin errors++; $display("FAIL rst_q got=%b exp=0000", q); end
        if (phase !== 8'b0000_0001) begin errors++; $display("FAIL rst_phase got=%b exp=00000001", phase); end
        if ({busy, done, wrap, illegal} !== 4'b0000) begin
            errors++; $display("FAIL rst_flags got=%b exp=0000", {busy, done, wrap, illegal});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_loops();
        step(1'b1, 1'b0, 1'b0, 8'd2);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy_after_start got=%b exp=1", busy); end
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            checks += 3;
            if (q !== seq_val(i % 8)) begin errors++; $display("FAIL t1_q adv=%0d got=%b exp=%b", i, q, seq_val(i % 8)); end
            if (wrap !== (i == 8 || i == 16)) begin errors++; $display("FAIL t1_wrap adv=%0d got=%b", i, wrap); end
            if (done !== (i == 16)) begin errors++; $display("FAIL t1_done adv=%0d got=%b", i, done); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t1_busy_end got=%b exp=0", busy); end
        step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_free_run_stop();
        int n_wrap;
        int n_done;
        n_wrap = 0; n_done = 0;
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'd0);
            if (wrap === 1'b1) n_wrap++;
            if (done === 1'b1) n_done++;
        end
        step(1'b0, 1'b1, 1'b0, 8'd0);
        if (done === 1'b1) n_done++;
        checks += 4;
        if (n_wrap != 2) begin errors++; $display("FAIL t2_wrap_count got=%0d exp=2", n_wrap); end
        if (n_done != 0) begin errors++; $display("FAIL t2_done_count got=%0d exp=0", n_done); end
        if (q !== 4'b0000) begin errors++; $display("FAIL t2_q_after_stop got=%b exp=0000", q); end
        if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_hold();
        int n_done;
        n_done = -1;
        step(1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (q !== 4'b0111) begin errors++; $display("FAIL t3_q_prehold got=%b exp=0111", q); end
        // Two hold edges plus the resume edge leave q parked for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, (i < 2), 8'd0);
            checks++;
            if (q !== 4'b0111) begin errors++; $display("FAIL t3_q_held cyc=%0d got=%b exp=0111", i, q); end
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (q !== 4'b1111) begin errors++; $display("FAIL t3_q_resume got=%b exp=1111", q); end
        for (int n = 8; n <= 20; n++) begin
            if (done === 1'b1) begin n_done = n - 1; break; end
            step(1'b0, 1'b0, 1'b0, 8'd0);
        end
        checks++;
        if (n_done != 11) begin errors++; $display("FAIL t3_done_latency got=%0d exp=11", n_done); end
        step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (q !== 4'b1110) begin errors++; $display("FAIL t4_q_pre got=%b exp=1110", q); end
        force dut.r_q = 4'b0101;
        m_q = 4'b0101;
        #1;
        checks++;
        if (phase !== 8'b0) begin errors++; $display("FAIL t4_phase_illegal got=%b exp=00000000", phase); end
        release dut.r_q;
        step(1'b0, 1'b0, 1'b0, 8'd0);
        checks += 4;
        if (q !== 4'b0000) begin errors++; $display("FAIL t4_q_fixed got=%b exp=0000", q); end
        if (illegal !== 1'b1) begin errors++; $display("FAIL t4_illegal got=%b exp=1", illegal); end
        if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy got=%b exp=1", busy); end
        if (wrap !== 1'b0) begin errors++; $display("FAIL t4_wrap got=%b exp=0", wrap); end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        checks++;
        if (illegal !== 1'b1) begin errors++; $display("FAIL t4_illegal_sticky got=%b exp=1", illegal); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (q !== 4'b0011) begin errors++; $display("FAIL t5_q_pre got=%b exp=0011", q); end
        force dut.r_illegal = 1'b1;
        #1;
        release dut.r_illegal;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        checks += 3;
        if (q !== 4'b0000) begin errors++; $display("FAIL t5_q_async got=%b exp=0000", q); end
        if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy_async got=%b exp=0", busy); end
        if (illegal !== 1'b0) begin errors++; $display("FAIL t5_illegal_async got=%b exp=0", illegal); end
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0, 8'd3);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t5_start_stop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 8; i++) begin
            step((i == 2), 1'b0, 1'b0, 8'd5);
            checks++;
            if (done !== (i == 8)) begin errors++; $display("FAIL t6_done adv=%0d got=%b", i, done); end
        end
        step(1'b0, 1'b0, 1'b0, 8'd0);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t6_busy_end got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_two_loops();
        test_free_run_stop();
        test_hold();
        test_illegal();
        test_async_reset();
        test_back_to_back();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
